cpa_trace_sequencer: RTL and testbench
======================================

// Module: cpa_trace_sequencer
// PURPOSE
//   Downstream of the CPA plaintext/key generator. Per trace it:
//   - pulses the generator's enable and captures the new plaintext/key
//   - starts the AES core and drives the scope trigger
//   - captures the ciphertext and streams a 32-byte frame (PT then CT) to the UART TX.
//   One trace per iteration; free-running or limited to a trace count.
// PARAMETERS
//   CYPHER_SIZE  128   key width, matches the generator's key port
//   TRIG_CYCLES  16    trigger high time in clk cycles (>=1)
//   GAP_CYCLES   1000  idle cycles between traces (>=0), lets the scope re-arm
//   TIMEOUT      4096  max cycles waiting for aes_done before abort
//   NUM_TRACES   0     traces per run; 0 = unlimited while run=1
// PORTS
//   clk          in   1            clock
//   reset        in   1            reset, asynchronous, active-high
//   run          in   1            level; 1 = keep acquiring traces
//   gen_ena      out  1            1-cycle pulse advancing the generator
//   plainText    in   128          generator plaintext (registered at generator)
//   cypher_key   in   CYPHER_SIZE  generator key
//   aes_pt       out  128          held plaintext to AES core
//   aes_key      out  CYPHER_SIZE  held key to AES core
//   aes_start    out  1            1-cycle start pulse
//   aes_done     in   1            AES completion strobe
//   aes_ct       in   128          ciphertext, valid when aes_done=1
//   trigger      out  1            scope trigger
//   tx_data      out  8            frame byte
//   tx_valid     out  1            tx_data valid
//   tx_ready     in   1            UART accepts byte
//   trace_count  out  32           completed traces since reset; wraps at 2^32
//   busy         out  1            1 when state != IDLE
//   timeout_err  out  1            sticky; set on AES timeout, cleared by reset only
// BEHAVIOUR
//   Reset: every output is 0, all registers are 0, state = IDLE.
//   Reset mid-trace aborts immediately; there is no partial frame recovery.
//   FSM states:
//   - IDLE: on run=1, go to ADV.
//   - ADV: gen_ena=1 for exactly 1 cycle, then LATCH.
//   - LATCH: plainText is valid one cycle after the gen_ena edge.
//     aes_pt<=plainText, aes_key<=cypher_key, then START.
//   - START: aes_start=1 for 1 cycle; trigger rises the same cycle.
//     trigger stays high for TRIG_CYCLES cycles, independent of later states.
//   - WAIT: capture aes_ct on aes_done=1, then SEND.
//     aes_done in the same cycle as aes_start is ignored.
//     If TIMEOUT cycles pass without aes_done: set timeout_err, drop trigger, go to IDLE.
//     trace_count is not incremented on a timeout.
//   - SEND: 32 bytes in order aes_pt[127:120] .. aes_pt[7:0], aes_ct[127:120] .. aes_ct[7:0].
//     Standard valid/ready: a byte transfers when tx_valid & tx_ready.
//     tx_data stays stable while tx_valid=1 and tx_ready=0; tx_valid never drops mid-frame.
//     After byte 31 transfers: tx_valid=0 the next cycle, then GAP.
//   - GAP: wait GAP_CYCLES cycles; GAP_CYCLES=0 means a single pass-through cycle.
//     trace_count increments by 1 on GAP entry.
//     Exit: if run=1 and (NUM_TRACES==0 or count_this_run<NUM_TRACES) go to ADV, else IDLE.
//   Run handling:
//   - count_this_run clears on the IDLE->ADV transition.
//   - run=0 mid-trace finishes the current trace, including its frame, then returns to IDLE.
//   Min trace latency, ADV to first tx_valid: 3 cycles + AES latency.
//   aes_pt/aes_key are held stable from LATCH until the next LATCH.
// STRUCTURE
//   Shared package cpa_pkg:
//   - state enum (IDLE, ADV, LATCH, START, WAIT, SEND, GAP)
//   - FRAME_BYTES=32
//   - BYTE_IDX_W=5
//   Sub-module cpa_byte_serializer (in: 256-bit frame + load; out: valid/ready byte stream
//   + last). It owns the byte index and the handshake.
//   Trigger timer and timeout counter stay in the top module.
// TESTING
//   Mock AES: done 10 cycles after start, ct = pt ^ {key}.
//   1. run=1, NUM_TRACES=1, tx_ready=1, pt=0x000..0001, key=1 -> gen_ena pulses once;
//      aes_start one cycle after LATCH; trigger high 16 cycles; 32 bytes out,
//      last 16 bytes all 00 (ct=0); trace_count=1; busy=0.
//   2. tx_ready toggling 1/0 each cycle -> no byte lost or repeated;
//      tx_data stable while stalled; 32 transfers total.
//   3. Mock AES never asserts done -> after 4096 cycles timeout_err=1, state IDLE,
//      trace_count unchanged, trigger=0.
//   4. NUM_TRACES=0, run dropped during SEND of trace 3 -> trace 3 frame completes;
//      trace_count=3; no further gen_ena.
//   5. reset asserted in WAIT -> all outputs 0 asynchronously;
//      after release with run=1, a fresh trace starts cleanly.
//   6. GAP_CYCLES=0, NUM_TRACES=2 -> back-to-back traces;
//      exactly 2 gen_ena pulses; 64 bytes; trace_count=2.

Source files
------------

// File: rtl/cpa_pkg.sv
// rtl/cpa_pkg.sv - shared types and frame constants for the CPA trace sequencer
package cpa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADV,
    LATCH,
    START,
    WAIT,
    SEND,
    GAP
  } state_t;

  localparam int FRAME_BYTES = 32;
  localparam int BYTE_IDX_W  = 5;

endpackage

// File: rtl/cpa_trace_sequencer_if.sv
// rtl/cpa_trace_sequencer_if.sv - AES core and UART TX byte-stream bus of the sequencer
interface cpa_trace_sequencer_if #(
  parameter int CYPHER_SIZE = 128
);
  logic [127:0]             aes_pt;
  logic [CYPHER_SIZE-1:0]   aes_key;
  logic                     aes_start;
  logic                     aes_done;
  logic [127:0]             aes_ct;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;

  modport master (
    output aes_pt, aes_key, aes_start, tx_data, tx_valid,
    input  aes_done, aes_ct, tx_ready
  );

  modport slave (
    input  aes_pt, aes_key, aes_start, tx_data, tx_valid,
    output aes_done, aes_ct, tx_ready
  );
endinterface

// File: rtl/cpa_byte_serializer.sv
// rtl/cpa_byte_serializer.sv - shifts a 256-bit PT/CT frame out MSB byte first over valid/ready
module cpa_byte_serializer
  import cpa_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_i,
  input  logic [FRAME_BYTES*8-1:0]  frame_i,
  output logic [7:0]                data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o
);

  logic [FRAME_BYTES*8-1:0] frame_q;
  logic [BYTE_IDX_W-1:0]    idx_q;
  logic                     valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      frame_q <= frame_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      // The frame is fully shifted out after the last byte, so tx_data idles at 0.
      frame_q <= frame_q << 8;
      idx_q   <= idx_q + 1'b1;
      if (idx_q == BYTE_IDX_W'(FRAME_BYTES - 1)) valid_q <= 1'b0;
    end
  end

  assign data_o  = frame_q[FRAME_BYTES*8-1 -: 8];
  assign valid_o = valid_q;
  assign last_o  = valid_q && (idx_q == BYTE_IDX_W'(FRAME_BYTES - 1));

endmodule

// File: rtl/cpa_trace_sequencer.sv
// rtl/cpa_trace_sequencer.sv - per-trace sequencing: generator advance, AES start, scope trigger, UART frame
module cpa_trace_sequencer
  import cpa_pkg::*;
#(
  parameter int CYPHER_SIZE = 128,
  parameter int TRIG_CYCLES = 16,
  parameter int GAP_CYCLES  = 1000,
  parameter int TIMEOUT     = 4096,
  parameter int NUM_TRACES  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic                   gen_ena,
  input  logic [127:0]           plainText,
  input  logic [CYPHER_SIZE-1:0] cypher_key,
  cpa_trace_sequencer_if.master  bus,
  output logic                   trigger,
  output logic [31:0]            trace_count,
  output logic                   busy,
  output logic                   timeout_err
);

  state_t                 state_q;
  logic                   gen_ena_q, aes_start_q, trigger_q, tmo_err_q, spent_q;
  logic [127:0]           pt_q;
  logic [CYPHER_SIZE-1:0] key_q;
  logic [31:0]            trig_cnt_q, tmo_cnt_q, gap_cnt_q, run_cnt_q, trace_cnt_q;
  logic                   load, last, frame_done, gap_last;

  assign load       = (state_q == WAIT) && bus.aes_done;
  assign frame_done = bus.tx_valid && bus.tx_ready && last;
  assign gap_last   = (GAP_CYCLES <= 1) || (gap_cnt_q == 32'(GAP_CYCLES - 1));

  // A limited run marks itself spent so a held-high run does not restart it; run=0 re-arms.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gen_ena_q   <= 1'b0;
      aes_start_q <= 1'b0;
      trigger_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      spent_q     <= 1'b0;
      pt_q        <= '0;
      key_q       <= '0;
      trig_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      run_cnt_q   <= '0;
      trace_cnt_q <= '0;
    end else begin
      gen_ena_q   <= 1'b0;
      aes_start_q <= 1'b0;
      if (trigger_q) begin
        if (trig_cnt_q == '0) trigger_q <= 1'b0;
        else trig_cnt_q <= trig_cnt_q - 32'd1;
      end
      if (!run) spent_q <= 1'b0;

      case (state_q)
        IDLE: if (run && !spent_q) begin
          state_q   <= ADV;
          gen_ena_q <= 1'b1;
          run_cnt_q <= '0;
        end
        ADV: state_q <= LATCH;
        LATCH: begin
          pt_q        <= plainText;
          key_q       <= cypher_key;
          aes_start_q <= 1'b1;
          trigger_q   <= 1'b1;
          trig_cnt_q  <= 32'(TRIG_CYCLES - 1);
          state_q     <= START;
        end
        START: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (bus.aes_done) begin
            state_q <= SEND;
          end else if (tmo_cnt_q == 32'(TIMEOUT - 1)) begin
            tmo_err_q <= 1'b1;
            trigger_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
        end
        SEND: if (frame_done) begin
          state_q     <= GAP;
          gap_cnt_q   <= '0;
          trace_cnt_q <= trace_cnt_q + 32'd1;
          run_cnt_q   <= run_cnt_q + 32'd1;
        end
        GAP: begin
          if (gap_last) begin
            if (run && (NUM_TRACES == 0 || run_cnt_q < 32'(NUM_TRACES))) begin
              state_q   <= ADV;
              gen_ena_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              spent_q <= run;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cpa_byte_serializer u_ser (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .frame_i ({pt_q, bus.aes_ct}),
    .data_o  (bus.tx_data),
    .valid_o (bus.tx_valid),
    .ready_i (bus.tx_ready),
    .last_o  (last)
  );

  assign bus.aes_pt    = pt_q;
  assign bus.aes_key   = key_q;
  assign bus.aes_start = aes_start_q;
  assign gen_ena       = gen_ena_q;
  assign trigger       = trigger_q;
  assign trace_count   = trace_cnt_q;
  assign busy          = (state_q != IDLE);
  assign timeout_err   = tmo_err_q;

endmodule

// File: tb/tb_cpa_trace_sequencer.sv
// tb/tb_cpa_trace_sequencer.sv - directed bench: three sequencer configs with mock generator and AES
module tb_cpa_trace_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [255:0] frame_of(input logic [7:0] q [256], input int base);
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < 32; i++) f = {f[247:0], q[(base + i) % 256]};
    return f;
  endfunction

  // Instance 0: NUM_TRACES=1; instance 1: free-running; instance 2: GAP_CYCLES=0, NUM_TRACES=2.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int NT = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
    localparam int GP = (g == 0) ? 50 : ((g == 1) ? 20 : 0);

    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        hang = 1'b0;
    logic        rdy_mode = 1'b0;
    logic        tx_ready = 1'b0;
    logic        gen_ena, trigger, busy, timeout_err, done;
    logic [31:0] trace_count;
    logic [127:0] pt_q;
    logic [3:0]  acnt;

    cpa_trace_sequencer_if #(.CYPHER_SIZE(128)) bus ();
    assign bus.aes_done = done;
    assign bus.aes_ct   = bus.aes_pt ^ bus.aes_key;
    assign bus.tx_ready = tx_ready;

    cpa_trace_sequencer #(
      .CYPHER_SIZE(128), .TRIG_CYCLES(16), .GAP_CYCLES(GP), .TIMEOUT(4096), .NUM_TRACES(NT)
    ) dut (
      .clk(clk), .reset(rst), .run(run), .gen_ena(gen_ena), .plainText(pt_q),
      .cypher_key(128'h1), .bus(bus), .trigger(trigger), .trace_count(trace_count),
      .busy(busy), .timeout_err(timeout_err)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) pt_q <= '0;
      else if (gen_ena) pt_q <= pt_q + 128'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acnt <= '0;
        done <= 1'b0;
      end else begin
        done <= 1'b0;
        if (bus.aes_start) acnt <= 4'd9;
        else if (acnt != 4'd0) begin
          acnt <= acnt - 4'd1;
          if (acnt == 4'd1 && !hang) done <= 1'b1;
        end
      end
    end

    always @(posedge clk) begin
      #1;
      tx_ready = rdy_mode ? ~tx_ready : 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int gen_cnt = 0, gen_cyc = 0, start_gap = -1, start_cyc = 0, trig_hi = 0;
    int rx_n = 0, stall_viol = 0, drop_viol = 0, dbl_gen = 0;
    logic trig_at_start = 1'b0, pgen = 1'b0, pstall = 1'b0, pv = 1'b0;
    logic [7:0] pdata = 8'h00;
    logic [7:0] rx_q [256];

    always @(negedge clk) begin
      if (gen_ena) begin
        gen_cnt++;
        gen_cyc = cyc;
        if (pgen) dbl_gen++;
      end
      pgen = gen_ena;
      if (bus.aes_start) begin
        start_gap     = cyc - gen_cyc;
        start_cyc     = cyc;
        trig_at_start = trigger;
      end
      if (trigger) trig_hi++;
      if (pstall && bus.tx_valid && bus.tx_data !== pdata) stall_viol++;
      if (pv && !bus.tx_valid && (rx_n % 32) != 0) drop_viol++;
      if (bus.tx_valid && bus.tx_ready) begin
        rx_q[rx_n % 256] = bus.tx_data;
        rx_n++;
      end
      pstall = bus.tx_valid && !bus.tx_ready;
      pdata  = bus.tx_data;
      pv     = bus.tx_valid;
    end
  end

  int b_gen, b_rx, b_trig;
  logic [255:0] f;

  initial begin
    repeat (3) tick();
    check_eq("rst_busy", g_inst[0].busy, 0);
    check_eq("rst_trace_count", g_inst[0].trace_count, 0);
    check_eq("rst_tx_valid", g_inst[0].bus.tx_valid, 0);
    check_eq("rst_aes_pt", g_inst[0].bus.aes_pt, 0);
    check_eq("rst_trigger", g_inst[0].trigger, 0);
    check_eq("rst_timeout_err", g_inst[0].timeout_err, 0);
    g_inst[0].rst = 1'b0;
    g_inst[1].rst = 1'b0;
    g_inst[2].rst = 1'b0;
    repeat (2) tick();

    // single limited trace, ready always high
    b_gen = g_inst[0].gen_cnt; b_rx = g_inst[0].rx_n; b_trig = g_inst[0].trig_hi;
    g_inst[0].run = 1'b1;
    for (int k = 0; k < 3000 && g_inst[0].trace_count != 32'd1; k++) tick();
    check_eq("t1_trace_count", g_inst[0].trace_count, 1);
    repeat (80) tick();
    check_eq("t1_busy", g_inst[0].busy, 0);
    check_eq("t1_gen_pulses", g_inst[0].gen_cnt - b_gen, 1);
    check_eq("t1_gen_width", g_inst[0].dbl_gen, 0);
    check_eq("t1_start_after_gen", g_inst[0].start_gap, 2);
    check_eq("t1_trig_at_start", g_inst[0].trig_at_start, 1);
    check_eq("t1_trig_cycles", g_inst[0].trig_hi - b_trig, 16);
    check_eq("t1_bytes", g_inst[0].rx_n - b_rx, 32);
    check_eq("t1_aes_pt", g_inst[0].bus.aes_pt, 128'h1);
    f = frame_of(g_inst[0].rx_q, b_rx);
    check_eq("t1_frame_pt", f[255:128], 128'h1);
    check_eq("t1_frame_ct", f[127:0], 128'h0);
    g_inst[0].run = 1'b0;
    repeat (3) tick();

    // backpressure: tx_ready toggles every cycle
    b_rx = g_inst[0].rx_n;
    g_inst[0].rdy_mode = 1'b1;
    g_inst[0].run = 1'b1;
    for (int k = 0; k < 3000 && g_inst[0].trace_count != 32'd2; k++) tick();
    check_eq("t2_trace_count", g_inst[0].trace_count, 2);
    repeat (80) tick();
    check_eq("t2_busy", g_inst[0].busy, 0);
    check_eq("t2_bytes", g_inst[0].rx_n - b_rx, 32);
    check_eq("t2_stall_stable", g_inst[0].stall_viol, 0);
    check_eq("t2_valid_no_drop", g_inst[0].drop_viol, 0);
    f = frame_of(g_inst[0].rx_q, b_rx);
    check_eq("t2_frame_pt", f[255:128], 128'h2);
    check_eq("t2_frame_ct", f[127:0], 128'h3);
    g_inst[0].run = 1'b0;
    g_inst[0].rdy_mode = 1'b0;
    repeat (3) tick();

    // AES never completes
    g_inst[1].hang = 1'b1;
    g_inst[1].run = 1'b1;
    for (int k = 0; k < 6000 && !g_inst[1].timeout_err; k++) tick();
    g_inst[1].run = 1'b0;
    check_eq("t3_timeout_err", g_inst[1].timeout_err, 1);
    check_eq("t3_timeout_latency", g_inst[1].cyc - g_inst[1].start_cyc, 4097);
    check_eq("t3_busy", g_inst[1].busy, 0);
    check_eq("t3_trigger", g_inst[1].trigger, 0);
    check_eq("t3_trace_count", g_inst[1].trace_count, 0);
    repeat (10) tick();
    check_eq("t3_sticky", g_inst[1].timeout_err, 1);
    g_inst[1].rst = 1'b1;
    tick();
    check_eq("t3_cleared_by_reset", g_inst[1].timeout_err, 0);
    g_inst[1].rst = 1'b0;
    g_inst[1].hang = 1'b0;
    repeat (2) tick();

    // free-running, run dropped during the third frame
    b_gen = g_inst[1].gen_cnt; b_rx = g_inst[1].rx_n;
    g_inst[1].run = 1'b1;
    for (int k = 0; k < 3000 && (g_inst[1].rx_n - b_rx) < 69; k++) tick();
    check_eq("t4_mid_third_frame", g_inst[1].trace_count, 2);
    g_inst[1].run = 1'b0;
    for (int k = 0; k < 2000 && g_inst[1].busy; k++) tick();
    repeat (40) tick();
    check_eq("t4_busy", g_inst[1].busy, 0);
    check_eq("t4_trace_count", g_inst[1].trace_count, 3);
    check_eq("t4_bytes", g_inst[1].rx_n - b_rx, 96);
    check_eq("t4_gen_pulses", g_inst[1].gen_cnt - b_gen, 3);
    check_eq("t4_valid_no_drop", g_inst[1].drop_viol, 0);

    // asynchronous reset while waiting on AES
    g_inst[0].run = 1'b1;
    for (int k = 0; k < 500 && !g_inst[0].bus.aes_start; k++) tick();
    repeat (3) tick();
    check_eq("t5_trigger_before", g_inst[0].trigger, 1);
    g_inst[0].rst = 1'b1;
    #1;
    check_eq("t5_async_trigger", g_inst[0].trigger, 0);
    check_eq("t5_async_busy", g_inst[0].busy, 0);
    check_eq("t5_async_trace_count", g_inst[0].trace_count, 0);
    check_eq("t5_async_aes_pt", g_inst[0].bus.aes_pt, 0);
    check_eq("t5_async_aes_key", g_inst[0].bus.aes_key, 0);
    repeat (2) tick();
    b_gen = g_inst[0].gen_cnt; b_rx = g_inst[0].rx_n;
    g_inst[0].rst = 1'b0;
    for (int k = 0; k < 2000 && g_inst[0].trace_count != 32'd1; k++) tick();
    repeat (80) tick();
    check_eq("t5_trace_count", g_inst[0].trace_count, 1);
    check_eq("t5_gen_pulses", g_inst[0].gen_cnt - b_gen, 1);
    check_eq("t5_bytes", g_inst[0].rx_n - b_rx, 32);
    f = frame_of(g_inst[0].rx_q, b_rx);
    check_eq("t5_frame_pt", f[255:128], 128'h1);
    check_eq("t5_frame_ct", f[127:0], 128'h0);
    g_inst[0].run = 1'b0;

    // back-to-back traces with no gap
    b_gen = g_inst[2].gen_cnt; b_rx = g_inst[2].rx_n;
    g_inst[2].run = 1'b1;
    for (int k = 0; k < 2000 && g_inst[2].trace_count != 32'd2; k++) tick();
    repeat (40) tick();
    check_eq("t6_trace_count", g_inst[2].trace_count, 2);
    check_eq("t6_busy", g_inst[2].busy, 0);
    check_eq("t6_gen_pulses", g_inst[2].gen_cnt - b_gen, 2);
    check_eq("t6_bytes", g_inst[2].rx_n - b_rx, 64);
    f = frame_of(g_inst[2].rx_q, b_rx);
    check_eq("t6_frame0", f, {128'h1, 128'h0});
    f = frame_of(g_inst[2].rx_q, b_rx + 32);
    check_eq("t6_frame1", f, {128'h2, 128'h3});
    g_inst[2].run = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
